// File: rtl/dsconv_block_relu_maxpool_pkg.sv
// Shared types and constants for the ReLU6 + 2x2 max-pool block.
// Pixel format is signed 18-bit fixed point with FRAC_BITS fraction bits.
package dsconv_block_relu_maxpool_pkg;

    localparam int PIX_W         = 18;
    localparam int FRAC_BITS_DEF = 9;

    typedef logic signed [PIX_W-1:0] pix_t;

    typedef enum logic {
        TOP_ROW    = 1'b0,
        BOTTOM_ROW = 1'b1
    } pool_state_t;

    // Upper clamp of ReLU6 for a given fraction width.
    function automatic pix_t six_of(input int frac);
        return pix_t'(6 << frac);
    endfunction

    localparam pix_t SIX = six_of(FRAC_BITS_DEF);

    // Signed maximum of two pixels.
    function automatic pix_t smax(input pix_t a, input pix_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dsconv_block_relu6.sv
// Combinational ReLU6 clamp: negative -> 0, above six -> six.
// Operates on the shared signed pixel format.
module dsconv_block_relu6
    import dsconv_block_relu_maxpool_pkg::*;
#(
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic signed [PIX_W-1:0] x_i,
    output logic signed [PIX_W-1:0] y_o
);

    localparam pix_t SIX_L = six_of(FRAC_BITS);

    // Clamp the input into [0, six].
    always_comb begin
        y_o = x_i;
        if (x_i[PIX_W-1]) begin
            y_o = '0;
        end else if (x_i > SIX_L) begin
            y_o = SIX_L;
        end
    end

endmodule

// File: rtl/dsconv_block_relu_maxpool.sv
// Streaming ReLU6 followed by 2x2 stride-2 max pooling.
// Top rows fold pairs into a half-width line buffer; bottom rows emit.
module dsconv_block_relu_maxpool
    import dsconv_block_relu_maxpool_pkg::*;
#(
    parameter int IMG_W     = 32,
    parameter int IMG_H     = 32,
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [PIX_W-1:0] x,
    output logic signed [PIX_W-1:0] output_pixel,
    output logic                    ready,
    output logic                    frame_done
);

    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int BW = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1;
    localparam int BN = IMG_W / 2;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    pool_state_t     state_q;
    logic [CW-1:0]   col_q;
    logic [RW-1:0]   row_q;
    pix_t            hold_q;
    pix_t            out_q;
    logic            ready_q;
    logic            done_q;
    pix_t            buf_q [BN];

    pix_t            act;
    logic [BW-1:0]   idx;
    pix_t            pair_d;
    pix_t            col_max_d;
    logic            col_end;
    logic            row_end;

    dsconv_block_relu6 #(
        .FRAC_BITS(FRAC_BITS)
    ) u_relu6 (
        .x_i(x),
        .y_o(act)
    );

    // Window datapath: horizontal pair max and vertical merge with buffer.
    always_comb begin
        idx       = BW'(col_q >> 1);
        pair_d    = smax(hold_q, act);
        col_max_d = smax(buf_q[idx], act);
        col_end   = (col_q == COL_LAST);
        row_end   = (row_q == ROW_LAST);
    end

    // Line buffer keeps the top-row pair maxima; no reset needed.
    always_ff @(posedge clk) begin
        if (start && state_q == TOP_ROW && col_q[0]) begin
            buf_q[idx] <= pair_d;
        end
    end

    // Row FSM, position counters, hold register and registered output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TOP_ROW;
            col_q   <= '0;
            row_q   <= '0;
            hold_q  <= '0;
            out_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            if (start) begin
                unique case (state_q)
                    TOP_ROW: begin
                        if (!col_q[0]) begin
                            hold_q <= act;
                        end
                    end
                    BOTTOM_ROW: begin
                        if (!col_q[0]) begin
                            hold_q <= col_max_d;
                        end else begin
                            out_q   <= pair_d;
                            ready_q <= 1'b1;
                            done_q  <= col_end && row_end;
                        end
                    end
                    default: ;
                endcase
                if (col_end) begin
                    col_q <= '0;
                    if (row_end) begin
                        row_q   <= '0;
                        state_q <= TOP_ROW;
                    end else begin
                        row_q   <= row_q + 1'b1;
                        state_q <= (state_q == TOP_ROW) ? BOTTOM_ROW
                                                        : TOP_ROW;
                    end
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    assign output_pixel = out_q;
    assign ready        = ready_q;
    assign frame_done   = done_q;

endmodule

// File: tb/tb_dsconv_block_relu_maxpool.sv
// Scoreboard bench for the ReLU6 + 2x2 max-pool block (4x4 frames).
// A frame-image reference model predicts outputs; a monitor checks them.
module tb_dsconv_block_relu_maxpool;

    localparam int W   = 4;
    localparam int H   = 4;
    localparam int FB  = 9;
    localparam int SIX = 6 * (1 << FB);
    localparam int NPX = W * H;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic signed [17:0] x = '0;
    logic signed [17:0] output_pixel;
    logic               ready;
    logic               frame_done;

    dsconv_block_relu_maxpool #(
        .IMG_W(W),
        .IMG_H(H),
        .FRAC_BITS(FB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .x(x),
        .output_pixel(output_pixel),
        .ready(ready),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int val;
        bit last;
        int acc;
    } exp_t;

    exp_t q[$];
    int   got[$];
    int   fd_cnt = 0;
    int   total = 0;
    int   bad = 0;
    int   img[NPX];
    int   k = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int relu6(input int v);
        if (v < 0) return 0;
        if (v > SIX) return SIX;
        return v;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Reference: place the pixel in the frame image; a completed
    // window (odd row, odd column) yields the max of its four ReLU6 values.
    task automatic model(input int v);
        int r, c, m;
        exp_t e;
        img[k] = v;
        r = k / W;
        c = k % W;
        if ((r % 2 == 1) && (c % 2 == 1)) begin
            m = max2(max2(relu6(img[(r-1)*W + c-1]), relu6(img[(r-1)*W + c])),
                     max2(relu6(img[r*W + c-1]), relu6(img[r*W + c])));
            e.val  = m;
            e.last = (k == NPX - 1);
            e.acc  = cyc;
            q.push_back(e);
        end
        k = (k + 1) % NPX;
    endtask

    task automatic send(input int v);
        @(negedge clk);
        start = 1'b1;
        x     = 18'(v);
        model(v);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic drain();
        idle(1);
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        chk("drain_queue_empty", q.size(), 0);
    endtask

    task automatic begin_test();
        got.delete();
        fd_cnt = 0;
    endtask

    // Monitor: every ready must match the head of the scoreboard.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (ready) begin
            if (q.size() == 0) begin
                chk("spurious_ready", 1, 0);
            end else begin
                e = q.pop_front();
                chk("pixel", int'(output_pixel), e.val);
                chk("frame_done", int'(frame_done), int'(e.last));
                chk("latency", cyc - e.acc, 1);
            end
            got.push_back(int'(output_pixel));
            if (frame_done) fd_cnt++;
        end else if (frame_done) begin
            chk("frame_done_without_ready", 1, 0);
        end
    end

    initial begin
        int g;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_pixel", int'(output_pixel), 0);
        chk("reset_ready", int'(ready), 0);
        chk("reset_done", int'(frame_done), 0);
        rst = 1'b0;

        // Constant 100 frame, back-to-back pixels.
        begin_test();
        for (int i = 0; i < NPX; i++) send(100);
        drain();
        chk("const_count", got.size(), 4);
        for (int i = 0; i < got.size(); i++) chk("const_val", got[i], 100);
        chk("const_fd", fd_cnt, 1);

        // Clamp windows: upper and all-negative.
        begin_test();
        send(-50); send(4000); send(-1); send(-2);
        send(200); send(10);   send(-3); send(-4);
        for (int i = 0; i < 8; i++) send($urandom_range(0, 3000));
        drain();
        if (got.size() >= 2) begin
            chk("clamp_six", got[0], 3072);
            chk("clamp_zero", got[1], 0);
        end else begin
            chk("clamp_count", got.size(), 4);
        end

        // Index ramp, then the same ramp with 3-cycle stalls.
        for (int s = 0; s < 2; s++) begin
            begin_test();
            for (int i = 0; i < NPX; i++) begin
                send(i);
                if (s == 1) idle(3);
            end
            drain();
            chk("ramp_count", got.size(), 4);
            if (got.size() == 4) begin
                chk("ramp_0", got[0], 5);
                chk("ramp_1", got[1], 7);
                chk("ramp_2", got[2], 13);
                chk("ramp_3", got[3], 15);
            end
        end

        // Abort mid-frame with reset, then a clean ramp frame.
        for (int i = 0; i < 6; i++) send(1000 + i);
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        k     = 0;
        #1;
        chk("abort_reset_ready", int'(ready), 0);
        chk("abort_reset_pixel", int'(output_pixel), 0);
        @(negedge clk);
        rst = 1'b0;
        begin_test();
        for (int i = 0; i < NPX; i++) send(i);
        drain();
        chk("abort_count", got.size(), 4);
        if (got.size() == 4) begin
            chk("abort_0", got[0], 5);
            chk("abort_1", got[1], 7);
            chk("abort_2", got[2], 13);
            chk("abort_3", got[3], 15);
        end

        // Two back-to-back random frames.
        begin_test();
        for (int i = 0; i < 2 * NPX; i++) send(int'($urandom_range(0, 12000)) - 4000);
        drain();
        chk("b2b_count", got.size(), 8);
        chk("b2b_fd", fd_cnt, 2);

        // Random values with random gaps.
        begin_test();
        for (int i = 0; i < 6 * NPX; i++) begin
            send(int'($urandom_range(0, 12000)) - 4000);
            g = $urandom_range(0, 2);
            if (g != 0) idle(g);
        end
        drain();
        chk("rand_count", got.size(), 24);
        chk("rand_fd", fd_cnt, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dsconv_block_relu_maxpool.md
DSCONV_BLOCK_RELU_MAXPOOL -- requirements
Module: dsconv_block_relu_maxpool

Interface
REQ-001 SHALL have parameter IMG_W, default 32, meaning feature-map width in pixels; must be even and at least 2.
REQ-002 SHALL have parameter IMG_H, default 32, meaning feature-map height in pixels; must be even and at least 2.
REQ-003 SHALL have parameter FRAC_BITS, default 9, meaning fractional bits of the pixel fixed-point format.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 start  input  1  input pixel valid; one pixel accepted per cycle while high.
REQ-007 x  input  18 (signed)  batch-normalized pixel, raster order, row-major.
REQ-008 output_pixel  output  18 (signed)  pooled, activated pixel, registered.
REQ-009 ready  output  1  one-cycle pulse marking output_pixel valid.
REQ-010 frame_done  output  1  one-cycle pulse coincident with the last pooled pixel of a frame.

Function
REQ-011 SHALL apply ReLU6 to each accepted x: result 0 if x<0, SIX=6<<FRAC_BITS (3072 at default) if x>SIX, else x.
REQ-012 SHALL compute 2x2 max pooling, stride 2, over activated pixels; output count per frame = (IMG_W/2)*(IMG_H/2), in raster order.
REQ-013 SHALL track col (0..IMG_W-1) and row (0..IMG_H-1), advancing only on cycles with start=1.
REQ-014 SHALL use two-state FSM TOP_ROW (row even) / BOTTOM_ROW (row odd); transition after col=IMG_W-1 is accepted.
REQ-015 TOP_ROW: even col -> hold register = act; odd col -> line buffer entry [col/2] = max(hold, act).
REQ-016 BOTTOM_ROW: even col -> hold = max(buffer[col/2], act); odd col -> output_pixel = max(hold, act), ready=1 on next cycle.
REQ-017 Latency SHALL be exactly 1 cycle from acceptance of the bottom-right pixel of a window to ready=1.
REQ-018 ready and frame_done SHALL be low in every cycle not specified by REQ-016/REQ-020; output_pixel holds its last value otherwise.
REQ-019 start low SHALL stall: counters, FSM, hold and buffer unchanged; no gaps required between pixels and arbitrary gaps tolerated.
REQ-020 On acceptance of row=IMG_H-1, col=IMG_W-1: col, row wrap to 0, FSM to TOP_ROW, frame_done pulses with that output; the next start begins a new frame with no idle cycle.
REQ-021 Comparisons SHALL be signed 18-bit; all operands are already in [0, SIX] so no widening or saturation is needed after ReLU6.
REQ-022 Line buffer SHALL hold IMG_W/2 entries of 18 bits; entries are overwritten each TOP_ROW and never need clearing.

Reset
REQ-023 rst high SHALL asynchronously force output_pixel=0, ready=0, frame_done=0, col=0, row=0, hold=0, FSM=TOP_ROW.
REQ-024 Reset mid-frame SHALL abandon the partial frame; the first pixel accepted after release is treated as row 0, col 0.
REQ-025 Line buffer contents need not be reset.

Structure
REQ-026 Shared package SHALL hold pixel width (18), FRAC_BITS default, SIX constant and the FSM state typedef.
REQ-027 ReLU6 clamp SHALL be a combinational sub-module dsconv_block_relu6; the pooling datapath and counters live in the top.

Verification
REQ-028 IMG_W=IMG_H=4, all pixels 100, start held high -> 4 outputs of 100, ready pulses on cycles after pixels 5, 7, 13 and 15 (0-based: after the pixels at indices 5, 7, 13, 15); frame_done with the fourth.
REQ-029 Window [-50, 4000, 200, 10] -> output 3072; window [-1, -2, -3, -4] -> output 0.
REQ-030 Pixel value = index 0..15, 4x4 -> outputs 5, 7, 13, 15 in order.
REQ-031 Same stream with start low for 3 cycles after every pixel -> identical outputs; each ready 1 cycle after its window's last pixel.
REQ-032 Assert rst after 6 pixels, release, send a full 4x4 frame -> outputs match REQ-030 exactly, no output from the aborted frame.
REQ-033 Two back-to-back frames -> 8 outputs, frame_done pulses exactly twice.
